// File: rtl/iram_access_sequencer.sv
// Internal data RAM sequencer: arbitrates CPU and monitor requests, resolves
// @Ri pointer fetches, and drives the 256x8 RAM write port and sync read port.
module iram_access_sequencer #(
    parameter int MON_STARVE_LIMIT = 4
) (
    input  logic       CPUClock,
    input  logic       nRESET,
    input  logic       CPU_REQ,
    input  logic       CPU_WR,
    input  logic       CPU_IND,
    input  logic [7:0] CPU_ADDR,
    input  logic [7:0] CPU_WDATA,
    input  logic [1:0] PSW43,
    input  logic       iR_SEL,
    output logic       CPU_ACK,
    output logic       CPU_RVALID,
    output logic [7:0] CPU_RDATA,
    input  logic       MON_REQ,
    input  logic       MON_WR,
    input  logic [7:0] MON_ADDR,
    input  logic [7:0] MON_WDATA,
    output logic       MON_ACK,
    output logic       MON_RVALID,
    output logic [7:0] MON_RDATA,
    output logic       RAM_RD_EN,
    output logic [7:0] RAM_RD_ADDR,
    input  logic [7:0] RAM_RDATA,
    output logic       RAM_WR_EN,
    output logic [7:0] RAM_WR_ADDR,
    output logic [7:0] RAM_WR_DATA,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE, PTR_RD, PTR_LAT, ACCESS, RD_WAIT, RD_RET
    } state_t;

    localparam logic [3:0] LIMIT = 4'(MON_STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt;
    logic [7:0] ptr;
    logic       own_mon, op_wr, op_ind, op_sfr;
    logic [7:0] op_addr, op_wdata;
    logic       mon_wins, grant_mon, grant_cpu;
    logic [7:0] acc_addr;

    assign mon_wins  = MON_REQ && (!CPU_REQ || starve_cnt == LIMIT);
    assign grant_mon = (state == IDLE) && mon_wins;
    assign grant_cpu = (state == IDLE) && CPU_REQ && !mon_wins;
    assign acc_addr  = op_ind ? ptr : op_addr;

    always_ff @(posedge CPUClock or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        CPU_ACK     = 1'b0;
        MON_ACK     = 1'b0;
        RAM_RD_EN   = 1'b0;
        RAM_RD_ADDR = 8'h00;
        RAM_WR_EN   = 1'b0;
        RAM_WR_ADDR = 8'h00;
        RAM_WR_DATA = 8'h00;
        BUSY        = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (grant_cpu && CPU_IND)    state_nxt = PTR_RD;
                else if (grant_cpu || grant_mon) state_nxt = ACCESS;
            end
            PTR_RD: begin
                RAM_RD_EN   = 1'b1;
                RAM_RD_ADDR = op_addr;
                state_nxt   = PTR_LAT;
            end
            PTR_LAT: state_nxt = ACCESS;
            ACCESS: begin
                CPU_ACK = !own_mon;
                MON_ACK = own_mon;
                if (op_wr) begin
                    RAM_WR_EN   = !op_sfr;
                    RAM_WR_ADDR = op_sfr ? 8'h00 : acc_addr;
                    RAM_WR_DATA = op_sfr ? 8'h00 : op_wdata;
                    state_nxt   = IDLE;
                end else begin
                    RAM_RD_EN   = !op_sfr;
                    RAM_RD_ADDR = op_sfr ? 8'h00 : acc_addr;
                    state_nxt   = RD_WAIT;
                end
            end
            RD_WAIT: state_nxt = RD_RET;
            RD_RET:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner's fields are frozen at the grant edge; @Ri latches the Ri address.
    always_ff @(posedge CPUClock or negedge nRESET) begin
        if (!nRESET) begin
            own_mon  <= 1'b0;
            op_wr    <= 1'b0;
            op_ind   <= 1'b0;
            op_sfr   <= 1'b0;
            op_addr  <= 8'h00;
            op_wdata <= 8'h00;
        end else if (grant_mon) begin
            own_mon  <= 1'b1;
            op_wr    <= MON_WR;
            op_ind   <= 1'b0;
            op_sfr   <= 1'b0;
            op_addr  <= MON_ADDR;
            op_wdata <= MON_WDATA;
        end else if (grant_cpu) begin
            own_mon  <= 1'b0;
            op_wr    <= CPU_WR;
            op_ind   <= CPU_IND;
            op_sfr   <= !CPU_IND && CPU_ADDR[7];
            op_addr  <= CPU_IND ? {3'b000, PSW43, 2'b00, iR_SEL} : CPU_ADDR;
            op_wdata <= CPU_WDATA;
        end
    end

    always_ff @(posedge CPUClock or negedge nRESET) begin
        if (!nRESET) begin
            starve_cnt <= 4'd0;
        end else if (!MON_REQ || grant_mon) begin
            starve_cnt <= 4'd0;
        end else if (grant_cpu && starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge CPUClock or negedge nRESET) begin
        if (!nRESET) begin
            ptr        <= 8'h00;
            CPU_RDATA  <= 8'h00;
            MON_RDATA  <= 8'h00;
            CPU_RVALID <= 1'b0;
            MON_RVALID <= 1'b0;
        end else begin
            CPU_RVALID <= (state == RD_RET) && !own_mon;
            MON_RVALID <= (state == RD_RET) && own_mon;
            if (state == PTR_LAT) ptr <= RAM_RDATA;
            if (state == RD_RET) begin
                if (own_mon) MON_RDATA <= RAM_RDATA;
                else         CPU_RDATA <= op_sfr ? 8'h00 : RAM_RDATA;
            end
        end
    end

endmodule

// File: doc/iram_access_sequencer.md
# iram_access_sequencer

Sequences and arbitrates all accesses to the 8051 internal data RAM (256 x 8, one write port plus one synchronous read port). It takes requests from the CPU core and from the debug monitor. It resolves CPU indirect (@Ri) accesses in two RAM phases: pointer fetch from the active register bank, then data access. It drives the RAM address, enable and data pins, and returns read data with a valid strobe.

## Interface
Parameters:
- MON_STARVE_LIMIT, 4: number of consecutive CPU grants made while MON_REQ is high before the monitor is forced ahead (range 1-15).

Ports:
- CPUClock  in  1  system clock; all state updates on the rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- CPU_REQ  in  1  CPU access request; held with its fields until CPU_ACK.
- CPU_WR  in  1  1 = write, 0 = read.
- CPU_IND  in  1  1 = indirect via Ri, 0 = direct CPU_ADDR.
- CPU_ADDR  in  8  direct address.
- CPU_WDATA  in  8  write data.
- PSW43  in  2  active register bank (PSW[4:3]).
- iR_SEL  in  1  selects R0 or R1 for indirect access.
- CPU_ACK  out  1  one-cycle pulse: request consumed.
- CPU_RVALID  out  1  one-cycle pulse: CPU_RDATA valid.
- CPU_RDATA  out  8  registered read data.
- MON_REQ, MON_WR  in  1 each  monitor request and direction; the monitor always uses direct addressing.
- MON_ADDR, MON_WDATA  in  8 each  monitor address and data.
- MON_ACK, MON_RVALID  out  1 each  monitor handshake, same meaning as the CPU equivalents.
- MON_RDATA  out  8  registered monitor read data.
- RAM_RD_EN  out  1  read strobe; RAM_RDATA is valid in the following cycle.
- RAM_RD_ADDR  out  8  read address.
- RAM_RDATA  in  8  RAM read data.
- RAM_WR_EN  out  1  write strobe; the RAM writes on the edge ending the cycle.
- RAM_WR_ADDR, RAM_WR_DATA  out  8 each  write address and write data.
- BUSY  out  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, PTR_RD, PTR_LAT, ACCESS, RD_WAIT, RD_RET.
- IDLE samples requests at each edge and chooses a winner:
  - CPU wins by default.
  - The monitor wins if CPU_REQ is low, or if starve_cnt == MON_STARVE_LIMIT.
- starve_cnt (4 bits):
  - increments on each CPU grant made while MON_REQ is high;
  - clears on a monitor grant or whenever MON_REQ is low;
  - saturates at the limit.
- The winner's fields are latched at the grant edge. Later changes on the inputs are ignored.
- Direct grant goes to ACCESS.
- CPU indirect grant goes to PTR_RD, which issues RAM_RD_EN at address {3'b000, PSW43, 2'b00, iR_SEL}.
- PTR_LAT latches RAM_RDATA into ptr, then the FSM moves to ACCESS with address = ptr. The full 8-bit pointer is valid, so indirect accesses reach 0x80-0xFF.
- ACCESS:
  - asserts the winner's ACK;
  - for a write, asserts RAM_WR_EN with the latched address and data, then returns to IDLE;
  - for a read, asserts RAM_RD_EN, then goes to RD_WAIT.
- RD_WAIT goes to RD_RET. RD_RET registers RAM_RDATA into the winner's RDATA; RVALID is high in the cycle after RD_RET, and the FSM is back in IDLE.
- SFR-space guard (CPU direct with CPU_ADDR[7]=1):
  - a write is ACKed with RAM_WR_EN suppressed;
  - a read is ACKed, no RAM read is issued, and RVALID returns RDATA = 0x00 at the normal slot.
- Monitor accesses to 0x80-0xFF are unrestricted.
- RDATA holds its value until the next read by the same requester.

## Timing
- Reset values:
  - FSM = IDLE, starve_cnt = 0, ptr = 0.
  - All ACK, RVALID, RAM_RD_EN, RAM_WR_EN and BUSY outputs are 0.
  - All address, data and RDATA outputs are 0x00.
- Reset mid-operation:
  - The in-flight access is dropped.
  - A write whose RAM_WR_EN cycle is cut by reset is not guaranteed to land.
  - No ACK or RVALID appears after reset release until a new request is granted.
- Latency is counted from grant edge E0 (cycle n = the cycle after edge En-1):
  - Direct write: ACK and RAM_WR_EN in cycle 1.
  - Direct read: ACK and RAM_RD_EN in cycle 1; RVALID in cycle 4.
  - Indirect write: pointer read in cycle 1; ACK and RAM_WR_EN in cycle 3.
  - Indirect read: ACK in cycle 3; RVALID in cycle 6.
- Handshake:
  - The requester holds REQ and its fields until ACK.
  - REQ is not sampled during the ACK cycle; the earliest next grant is the edge following the FSM's return to IDLE.
  - A REQ that drops before ACK while the access is already in flight is still completed.
- Ordering: a write completes at the edge ending its ACCESS cycle, so a following pointer fetch or read of the same location returns the new data.

## Test plan
- Direct CPU write 0x3C←0xA5, then direct read of 0x3C -> ACK in cycle 1; RVALID in cycle 4 with CPU_RDATA = 0xA5.
- PSW43=2'b10, iR_SEL=1, RAM[0x11]=0x90, RAM[0x90]=0x5A; CPU indirect read -> pointer read at 0x11; RAM_RD_ADDR = 0x90 in cycle 3; CPU_RDATA = 0x5A in cycle 6.
- CPU direct write to 0x85 -> CPU_ACK=1 and RAM_WR_EN stays 0. Monitor write 0x85←0x77 -> RAM_WR_EN=1. CPU direct read of 0x85 -> RDATA = 0x00.
- CPU_REQ and MON_REQ held high continuously, MON_STARVE_LIMIT=4 -> grant order CPU×4, MON, CPU×4, MON.
- nRESET pulsed low during RD_WAIT of a monitor read -> BUSY=0 immediately; no MON_RVALID afterwards; the next request is served normally.
- Back-to-back CPU direct writes with REQ held high -> one ACK every 2 cycles; each ACK carries the fields present at its grant edge.
